// File: rtl/ghost_mode_sched.sv
// Ghost scatter/chase/frightened mode scheduler with fright save/restore.
// Optional flash warning output enabled by the GHOST_FLASH_EN macro.
module ghost_mode_sched #(
  parameter int SCATTER_FRAMES = 210,
  parameter int CHASE_FRAMES   = 600,
  parameter int FRIGHT_FRAMES  = 180,
  parameter int WARN_FRAMES    = 60,
  parameter int NUM_WAVES      = 4,
  parameter int NORMAL_SPEED   = 60,
  parameter int FRIGHT_SPEED   = 30
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       gameStart,
  input  logic       powerPellet,
  input  logic       pause,
  output logic [1:0] mode,
  output logic [7:0] ghostSpeed,
  output logic       reverse,
  output logic       flash,
  output logic [2:0] waveIdx,
  output logic [9:0] framesLeft
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCATTER = 2'd1,
    CHASE   = 2'd2,
    FRIGHT  = 2'd3
  } state_t;

  localparam logic [9:0] SC_F  = 10'(SCATTER_FRAMES);
  localparam logic [9:0] CH_F  = 10'(CHASE_FRAMES);
  localparam logic [9:0] FR_F  = 10'(FRIGHT_FRAMES);
  localparam logic [2:0] NW    = 3'(NUM_WAVES);
  localparam logic [7:0] NSPD  = 8'(NORMAL_SPEED);
  localparam logic [7:0] FSPD  = 8'(FRIGHT_SPEED);

  state_t     state_q, state_d;
  state_t     sv_state_q, sv_state_d;
  logic [9:0] frames_q, frames_d;
  logic [9:0] sv_frames_q, sv_frames_d;
  logic [2:0] wave_q, wave_d;
  logic       rev_q, rev_d;
  logic [7:0] speed_q, speed_d;
  logic       perm;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      sv_state_q  <= IDLE;
      frames_q    <= '0;
      sv_frames_q <= '0;
      wave_q      <= '0;
      rev_q       <= 1'b0;
      speed_q     <= '0;
    end else begin
      state_q     <= state_d;
      sv_state_q  <= sv_state_d;
      frames_q    <= frames_d;
      sv_frames_q <= sv_frames_d;
      wave_q      <= wave_d;
      rev_q       <= rev_d;
      speed_q     <= speed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sv_state_d  = sv_state_q;
    frames_d    = frames_q;
    sv_frames_d = sv_frames_q;
    wave_d      = wave_q;
    rev_d       = 1'b0;
    perm        = (state_q == CHASE) && (wave_q == NW);
    if (gameStart) begin
      state_d     = SCATTER;
      frames_d    = SC_F;
      wave_d      = '0;
      sv_state_d  = IDLE;
      sv_frames_d = '0;
    end else if (powerPellet && state_q != IDLE) begin
      // A retrigger keeps the context saved on first entry
      if (state_q != FRIGHT) begin
        sv_state_d  = state_q;
        sv_frames_d = frames_q;
      end
      state_d  = FRIGHT;
      frames_d = FR_F;
      rev_d    = 1'b1;
    end else if (startOfFrame && !pause &&
                 state_q != IDLE && !perm) begin
      if (frames_q > 10'd1) begin
        frames_d = frames_q - 10'd1;
      end else begin
        unique case (state_q)
          SCATTER: begin
            state_d  = CHASE;
            frames_d = CH_F;
            rev_d    = 1'b1;
          end
          CHASE: begin
            if (wave_q + 3'd1 == NW) begin
              wave_d   = NW;
              frames_d = '0;
            end else begin
              state_d  = SCATTER;
              wave_d   = wave_q + 3'd1;
              frames_d = SC_F;
              rev_d    = 1'b1;
            end
          end
          FRIGHT: begin
            state_d  = sv_state_q;
            frames_d = sv_frames_q;
          end
          default: ;
        endcase
      end
    end
    unique case (state_d)
      SCATTER, CHASE: speed_d = NSPD;
      FRIGHT:         speed_d = FSPD;
      default:        speed_d = '0;
    endcase
  end

`ifdef GHOST_FLASH_EN
  localparam logic [9:0] WARN_F = 10'(WARN_FRAMES);

  logic       flash_q, flash_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       warn_now, warn_nxt, counted;

  assign warn_now = (state_q == FRIGHT) && (frames_q <= WARN_F);
  assign warn_nxt = (state_d == FRIGHT) && (frames_d <= WARN_F);
  assign counted  = startOfFrame && !pause && !gameStart &&
                    !powerPellet && (state_q == FRIGHT);

  always_comb begin
    flash_d = 1'b0;
    fcnt_d  = '0;
    if (warn_nxt) begin
      if (!warn_now) begin
        flash_d = 1'b1;
      end else begin
        flash_d = flash_q;
        fcnt_d  = fcnt_q;
        if (counted) begin
          fcnt_d = fcnt_q + 3'd1;
          if (fcnt_q == 3'd7) flash_d = ~flash_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flash_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      flash_q <= flash_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign flash = flash_q;
`else
  assign flash = 1'b0;
`endif

  assign mode       = state_q;
  assign ghostSpeed = speed_q;
  assign reverse    = rev_q;
  assign waveIdx    = wave_q;
  assign framesLeft = frames_q;

endmodule

// File: tb/tb_ghost_mode_sched.sv
// Directed and random stimulus for ghost_mode_sched against an event-level
// reference model of the phase schedule.
module tb_ghost_mode_sched;

  localparam int SC = 5;
  localparam int CH = 7;
  localparam int FR = 6;
  localparam int WN = 3;
  localparam int NW = 2;
  localparam int NS = 60;
  localparam int FS = 30;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       gameStart = 1'b0;
  logic       powerPellet = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] mode;
  logic [7:0] ghostSpeed;
  logic       reverse;
  logic       flash;
  logic [2:0] waveIdx;
  logic [9:0] framesLeft;

  int checks = 0;
  int errors = 0;

  // reference model: 0 idle, 1 scatter, 2 chase, 3 fright
  int m_mode, m_frames, m_wave, m_sv_mode, m_sv_frames;
  int m_rev, m_fk, m_flash;
  bit m_warn;

  ghost_mode_sched #(
    .SCATTER_FRAMES(SC), .CHASE_FRAMES(CH), .FRIGHT_FRAMES(FR),
    .WARN_FRAMES(WN), .NUM_WAVES(NW),
    .NORMAL_SPEED(NS), .FRIGHT_SPEED(FS)
  ) dut (
    .clk(clk), .resetN(resetN),
    .startOfFrame(startOfFrame), .gameStart(gameStart),
    .powerPellet(powerPellet), .pause(pause),
    .mode(mode), .ghostSpeed(ghostSpeed), .reverse(reverse),
    .flash(flash), .waveIdx(waveIdx), .framesLeft(framesLeft)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_frames = 0; m_wave = 0;
    m_sv_mode = 0; m_sv_frames = 0;
    m_rev = 0; m_fk = 0; m_flash = 0; m_warn = 0;
  endtask

  task automatic model_step(input bit gs, input bit pp,
                            input bit sof, input bit pz);
    bit was_warn;
    bit counted;
    was_warn = m_warn;
    counted  = 0;
    m_rev    = 0;
    if (gs) begin
      m_mode = 1; m_frames = SC; m_wave = 0;
      m_sv_mode = 0; m_sv_frames = 0;
    end else if (pp && m_mode != 0) begin
      if (m_mode != 3) begin
        m_sv_mode = m_mode; m_sv_frames = m_frames;
      end
      m_mode = 3; m_frames = FR; m_rev = 1;
    end else if (sof && !pz && m_mode != 0 &&
                 !(m_mode == 2 && m_wave == NW)) begin
      counted  = (m_mode == 3);
      m_frames = m_frames - 1;
      if (m_frames == 0) begin
        if (m_mode == 1) begin
          m_mode = 2; m_frames = CH; m_rev = 1;
        end else if (m_mode == 2) begin
          if (m_wave + 1 == NW) m_wave = NW;
          else begin
            m_mode = 1; m_wave++; m_frames = SC; m_rev = 1;
          end
        end else begin
          m_mode = m_sv_mode; m_frames = m_sv_frames;
        end
      end
    end
    m_warn = (m_mode == 3) && (m_frames <= WN);
    if (m_warn && !was_warn) m_fk = 0;
    else if (m_warn && counted) m_fk++;
`ifdef GHOST_FLASH_EN
    m_flash = (m_warn && ((m_fk / 8) % 2 == 0)) ? 1 : 0;
`else
    m_flash = 0;
`endif
  endtask

  task automatic check_all(input string tag);
    int spd;
    spd = (m_mode == 0) ? 0 : (m_mode == 3) ? FS : NS;
    check({tag, ".mode"}, 32'(mode), m_mode);
    check({tag, ".speed"}, 32'(ghostSpeed), spd);
    check({tag, ".reverse"}, 32'(reverse), m_rev);
    check({tag, ".flash"}, 32'(flash), m_flash);
    check({tag, ".wave"}, 32'(waveIdx), m_wave);
    check({tag, ".frames"}, 32'(framesLeft), m_frames);
  endtask

  task automatic cyc(input string tag, input bit gs,
                     input bit pp, input bit sof);
    gameStart = gs; powerPellet = pp; startOfFrame = sof;
    @(posedge clk);
    #1;
    model_step(gs, pp, sof, pause);
    gameStart = 0; powerPellet = 0; startOfFrame = 0;
    check_all(tag);
  endtask

  task automatic frames(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 1);
  endtask

  task automatic async_reset(input string tag);
    #2 resetN = 1'b0;
    #1 model_reset();
    check_all(tag);
    @(posedge clk);
    #1 resetN = 1'b1;
  endtask

  initial begin
    model_reset();
    #3 check_all("reset");
    @(posedge clk);
    #1 resetN = 1'b1;
    cyc("idle_sof", 0, 0, 1);
    cyc("idle_pp", 0, 1, 0);
    check("idle_hold", 32'(mode), 0);

    cyc("start", 1, 0, 0);
    check("start_rev", 32'(reverse), 0);
    frames("sc0", SC);
    check("to_chase", 32'(mode), 2);
    check("to_chase_rev", 32'(reverse), 1);
    frames("ch0", CH);
    check("wave1", 32'(waveIdx), 1);
    frames("w1", SC + CH);
    check("perm_mode", 32'(mode), 2);
    check("perm_wave", 32'(waveIdx), 2);
    check("perm_frames", 32'(framesLeft), 0);
    frames("perm_hold", 5);

    cyc("restart", 1, 0, 0);
    check("restart_rev", 32'(reverse), 0);
    frames("rs_sc", SC);
    frames("rs_ch", 3);
    cyc("pp", 0, 1, 0);
    check("fr_speed", 32'(ghostSpeed), FS);
    check("fr_rev", 32'(reverse), 1);
    frames("fr", 3);
`ifdef GHOST_FLASH_EN
    check("flash_on", 32'(flash), 1);
`else
    check("flash_off", 32'(flash), 0);
`endif
    frames("fr_end", 3);
    check("resume_mode", 32'(mode), 2);
    check("resume_frames", 32'(framesLeft), 4);
    check("resume_rev", 32'(reverse), 0);

    cyc("pp2", 0, 1, 0);
    frames("rt", 3);
    cyc("retrig", 0, 1, 0);
    check("retrig_frames", 32'(framesLeft), FR);
    check("retrig_rev", 32'(reverse), 1);
    frames("rt_end", FR);
    check("rt_resume", 32'(framesLeft), 4);

    cyc("pp_sof", 0, 1, 1);
    check("pp_sof_frames", 32'(framesLeft), FR);
    cyc("gs_pp", 1, 1, 0);
    check("gs_pp_mode", 32'(mode), 1);
    check("gs_pp_wave", 32'(waveIdx), 0);

    pause = 1'b1;
    frames("paused", 10);
    check("pause_frames", 32'(framesLeft), SC);
    cyc("pause_pp", 0, 1, 0);
    pause = 1'b0;
    frames("unpause", 2);
    async_reset("midreset");
    frames("post_reset", 3);
    check("post_reset_idle", 32'(mode), 0);

    cyc("rnd_start", 1, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      bit gs, pp, sof;
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      gs  = ($urandom_range(0, 80) == 0);
      pp  = ($urandom_range(0, 25) == 0);
      sof = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 400) == 0) async_reset("rnd_reset");
      else cyc("rnd", gs, pp, sof);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
